// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between
// the processor data port (port 0) and the loader/debug port (port 1).

// Per-port request normalisation and stall generation.
module data_mem_arbiter_port #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              wr,
   input  logic              rd,
   input  logic [15:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              accept,
   output logic              req,
   output logic              is_wr,
   output logic [ADDR_W-1:0] maddr,
   output logic [DATA_W-1:0] mdata,
   output logic              waitreq
);
   logic unused_hi;

   // Write wins when both strobes are up; the read is dropped.
   assign req     = wr | rd;
   assign is_wr   = wr;
   assign maddr   = addr[ADDR_W-1:0];
   assign mdata   = wdata;
   assign waitreq = req & ~accept;

   if (ADDR_W < 16) begin : g_hi
      assign unused_hi = ^addr[15:ADDR_W];
   end else begin : g_nohi
      assign unused_hi = 1'b0;
   end
endmodule

module data_mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [15:0]       DataAddr,
   input  logic [DATA_W-1:0] DataOut,
   input  logic              WriteData,
   input  logic              ReadData,
   output logic [DATA_W-1:0] DataIn,
   output logic              DataWaitreq,
   input  logic [15:0]       LdAddr,
   input  logic [DATA_W-1:0] LdWrData,
   input  logic              LdWrite,
   input  logic              LdRead,
   output logic [DATA_W-1:0] LdRdData,
   output logic              LdWaitreq,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWrData,
   output logic              MemWrEn,
   input  logic [DATA_W-1:0] MemRdData
);
   localparam int NP = 2;

   typedef enum logic {IDLE = 1'b0, RD = 1'b1} state_t;

   state_t state, state_nx;
   logic   own, own_nx;
   logic   last_gnt, last_gnt_nx;
   logic   gnt_vld, gnt_sel;

   logic [NP-1:0]             wr_in, rd_in, req, is_wr, accept, waitreq;
   logic [NP-1:0][15:0]       addr_in;
   logic [NP-1:0][DATA_W-1:0] wdata_in, mdata;
   logic [NP-1:0][ADDR_W-1:0] maddr;

   assign wr_in    = {LdWrite, WriteData};
   assign rd_in    = {LdRead, ReadData};
   assign addr_in  = {LdAddr, DataAddr};
   assign wdata_in = {LdWrData, DataOut};

   for (genvar p = 0; p < NP; p++) begin : g_port
      data_mem_arbiter_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
         .wr      (wr_in[p]),
         .rd      (rd_in[p]),
         .addr    (addr_in[p]),
         .wdata   (wdata_in[p]),
         .accept  (accept[p]),
         .req     (req[p]),
         .is_wr   (is_wr[p]),
         .maddr   (maddr[p]),
         .mdata   (mdata[p]),
         .waitreq (waitreq[p])
      );
   end

   assign DataWaitreq = waitreq[0];
   assign LdWaitreq   = waitreq[1];
   assign DataIn      = MemRdData;
   assign LdRdData    = MemRdData;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state    <= IDLE;
         own      <= 1'b0;
         last_gnt <= 1'b1;   // processor wins the first tie
      end else begin
         state    <= state_nx;
         own      <= own_nx;
         last_gnt <= last_gnt_nx;
      end
   end

   always_comb begin
      gnt_vld     = |req;
      gnt_sel     = (req[0] & req[1]) ? ~last_gnt : req[1];
      state_nx    = state;
      own_nx      = own;
      last_gnt_nx = last_gnt;
      accept      = '0;
      MemAddr     = maddr[0];
      MemWrData   = mdata[0];
      MemWrEn     = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_vld) begin
               last_gnt_nx = gnt_sel;
               MemAddr     = maddr[gnt_sel];
               MemWrData   = mdata[gnt_sel];
               if (is_wr[gnt_sel]) begin
                  MemWrEn         = 1'b1;
                  accept[gnt_sel] = 1'b1;
               end else begin
                  state_nx = RD;
                  own_nx   = gnt_sel;
               end
            end
         end
         RD: begin
            // Registered memory data lands now; owner completes even if it dropped.
            MemAddr     = maddr[own];
            accept[own] = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboarded bench for data_mem_arbiter with a behavioural 4096x16 memory.
module tb_data_mem_arbiter;
   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic [15:0] DataAddr = '0, DataOut = '0, LdAddr = '0, LdWrData = '0;
   logic        WriteData = 1'b0, ReadData = 1'b0, LdWrite = 1'b0, LdRead = 1'b0;
   logic [15:0] DataIn, LdRdData, MemWrData, MemRdData;
   logic        DataWaitreq, LdWaitreq, MemWrEn;
   logic [11:0] MemAddr;

   logic [15:0] mem [0:4095];
   logic [15:0] p_q [$];
   logic [15:0] l_q [$];
   logic [15:0] p_e, l_e;
   int ntests = 0, nfail = 0;

   data_mem_arbiter #(.ADDR_W(12), .DATA_W(16)) dut (
      .Clock(Clock), .Resetn(Resetn),
      .DataAddr(DataAddr), .DataOut(DataOut), .WriteData(WriteData), .ReadData(ReadData),
      .DataIn(DataIn), .DataWaitreq(DataWaitreq),
      .LdAddr(LdAddr), .LdWrData(LdWrData), .LdWrite(LdWrite), .LdRead(LdRead),
      .LdRdData(LdRdData), .LdWaitreq(LdWaitreq),
      .MemAddr(MemAddr), .MemWrData(MemWrData), .MemWrEn(MemWrEn), .MemRdData(MemRdData)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      if (MemWrEn) mem[MemAddr] <= MemWrData;
      MemRdData <= mem[MemAddr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Read completions are popped from the per-port expected-data queues.
   always @(negedge Clock) begin
      if (Resetn) begin
         if (ReadData && !WriteData && !DataWaitreq) begin
            if (p_q.size() == 0) chk("p_unexpected_rd", 32'd1, 32'd0);
            else begin
               p_e = p_q.pop_front();
               chk("p_rd_data", 32'(DataIn), 32'(p_e));
            end
         end
         if (LdRead && !LdWrite && !LdWaitreq) begin
            if (l_q.size() == 0) chk("l_unexpected_rd", 32'd1, 32'd0);
            else begin
               l_e = l_q.pop_front();
               chk("l_rd_data", 32'(LdRdData), 32'(l_e));
            end
         end
      end
   end

   task automatic do_reset();
      Resetn = 1'b0;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      Resetn = 1'b1;
   endtask

   // One complete transaction on one port; d is write data or expected read data.
   task automatic xact(input bit ld, input bit wr, input logic [15:0] a, input logic [15:0] d);
      int n = 0;
      if (!wr) begin
         if (ld) l_q.push_back(d); else p_q.push_back(d);
      end
      if (ld) begin LdAddr = a; LdWrData = d; LdWrite = wr; LdRead = !wr; end
      else begin DataAddr = a; DataOut = d; WriteData = wr; ReadData = !wr; end
      @(negedge Clock);
      while ((ld ? LdWaitreq : DataWaitreq) && n < 8) begin
         @(posedge Clock); #1;
         @(negedge Clock);
         n++;
      end
      if (ld ? LdWaitreq : DataWaitreq) chk(ld ? "l_timeout" : "p_timeout", 32'd1, 32'd0);
      @(posedge Clock); #1;
      if (ld) begin LdWrite = 1'b0; LdRead = 1'b0; end
      else begin WriteData = 1'b0; ReadData = 1'b0; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [7:0] dw_exp, lw_exp;
      int n;

      // Reset state, no requests
      DataAddr = 16'h0ABC;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      Resetn = 1'b1;
      @(negedge Clock);
      chk("rst_wren", 32'(MemWrEn), 32'd0);
      chk("rst_dwait", 32'(DataWaitreq), 32'd0);
      chk("rst_lwait", 32'(LdWaitreq), 32'd0);
      chk("idle_addr", 32'(MemAddr), 32'h0ABC);
      @(posedge Clock); #1;

      // Uncontested write then read-back
      DataAddr = 16'h000A; DataOut = 16'h1234; WriteData = 1'b1;
      @(negedge Clock);
      chk("w_wren", 32'(MemWrEn), 32'd1);
      chk("w_addr", 32'(MemAddr), 32'h00A);
      chk("w_data", 32'(MemWrData), 32'h1234);
      chk("w_dwait", 32'(DataWaitreq), 32'd0);
      @(posedge Clock); #1;
      WriteData = 1'b0; ReadData = 1'b1; p_q.push_back(16'h1234);
      @(negedge Clock);
      chk("r_stall", 32'(DataWaitreq), 32'd1);
      chk("r_wren", 32'(MemWrEn), 32'd0);
      @(posedge Clock); #1;
      @(negedge Clock);
      chk("r_done", 32'(DataWaitreq), 32'd0);
      @(posedge Clock); #1;
      ReadData = 1'b0;

      // Write tie right after reset: processor first, loader next
      do_reset();
      DataAddr = 16'h0001; DataOut = 16'hAAAA; WriteData = 1'b1;
      LdAddr = 16'h0002; LdWrData = 16'h5555; LdWrite = 1'b1;
      @(negedge Clock);
      chk("tie1_addr", 32'(MemAddr), 32'h001);
      chk("tie1_dwait", 32'(DataWaitreq), 32'd0);
      chk("tie1_lwait", 32'(LdWaitreq), 32'd1);
      @(posedge Clock); #1;
      WriteData = 1'b0;
      @(negedge Clock);
      chk("tie2_addr", 32'(MemAddr), 32'h002);
      chk("tie2_data", 32'(MemWrData), 32'h5555);
      chk("tie2_lwait", 32'(LdWaitreq), 32'd0);
      @(posedge Clock); #1;
      LdWrite = 1'b0;
      xact(1'b1, 1'b0, 16'h0001, 16'hAAAA);
      xact(1'b0, 1'b0, 16'h0002, 16'h5555);

      // Both ports reading continuously: round-robin alternation
      xact(1'b0, 1'b1, 16'h0010, 16'h1111);
      xact(1'b1, 1'b1, 16'h0020, 16'h2222);
      do_reset();
      dw_exp = 8'b1101_1101;
      lw_exp = 8'b0111_0111;
      p_q.push_back(16'h1111); p_q.push_back(16'h1111);
      l_q.push_back(16'h2222); l_q.push_back(16'h2222);
      DataAddr = 16'h0010; ReadData = 1'b1;
      LdAddr = 16'h0020; LdRead = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         chk("rr_dwait", 32'(DataWaitreq), 32'(dw_exp[i]));
         chk("rr_lwait", 32'(LdWaitreq), 32'(lw_exp[i]));
         if (i == 2) chk("rr_l_addr", 32'(MemAddr), 32'h020);
         @(posedge Clock); #1;
      end
      ReadData = 1'b0; LdRead = 1'b0;
      chk("rr_p_count", 32'(p_q.size()), 32'd0);
      chk("rr_l_count", 32'(l_q.size()), 32'd0);

      // Top address read with a loader write arriving during RD
      xact(1'b0, 1'b1, 16'hFFFF, 16'hBEEF);
      DataAddr = 16'hFFFF; ReadData = 1'b1; p_q.push_back(16'hBEEF);
      @(negedge Clock);
      chk("top_addr1", 32'(MemAddr), 32'hFFF);
      @(posedge Clock); #1;
      LdAddr = 16'h0005; LdWrData = 16'h5A5A; LdWrite = 1'b1;
      @(negedge Clock);
      chk("top_addr2", 32'(MemAddr), 32'hFFF);
      chk("top_rd_wren", 32'(MemWrEn), 32'd0);
      chk("top_lwait", 32'(LdWaitreq), 32'd1);
      chk("top_dwait", 32'(DataWaitreq), 32'd0);
      @(posedge Clock); #1;
      ReadData = 1'b0;
      @(negedge Clock);
      chk("ldw_wren", 32'(MemWrEn), 32'd1);
      chk("ldw_addr", 32'(MemAddr), 32'h005);
      chk("ldw_lwait", 32'(LdWaitreq), 32'd0);
      @(posedge Clock); #1;
      LdWrite = 1'b0;
      xact(1'b1, 1'b0, 16'h0005, 16'h5A5A);

      // Reset while in RD: aborted, then re-arbitrated once reset lifts
      xact(1'b0, 1'b1, 16'h0040, 16'h4444);
      DataAddr = 16'h0040; ReadData = 1'b1; p_q.push_back(16'h4444);
      @(negedge Clock);
      chk("rrd_stall", 32'(DataWaitreq), 32'd1);
      @(posedge Clock); #1;
      #2 Resetn = 1'b0;
      @(negedge Clock);
      chk("rrd_rst_dwait", 32'(DataWaitreq), 32'd1);
      chk("rrd_rst_wren", 32'(MemWrEn), 32'd0);
      @(posedge Clock); #1;
      Resetn = 1'b1;
      n = 0;
      while (n < 6) begin
         @(negedge Clock);
         n++;
         chk("rrd_wren", 32'(MemWrEn), 32'd0);
         if (!DataWaitreq) break;
         @(posedge Clock); #1;
      end
      chk("rrd_latency", 32'(n), 32'd2);
      @(posedge Clock); #1;
      ReadData = 1'b0;

      // Loader write+read together behaves as a write
      LdAddr = 16'h0030; LdWrData = 16'h0BEE; LdWrite = 1'b1; LdRead = 1'b1;
      @(negedge Clock);
      chk("wr_rd_lwait", 32'(LdWaitreq), 32'd0);
      chk("wr_rd_wren", 32'(MemWrEn), 32'd1);
      chk("wr_rd_data", 32'(MemWrData), 32'h0BEE);
      @(posedge Clock); #1;
      LdWrite = 1'b0; LdRead = 1'b0;
      xact(1'b1, 1'b0, 16'h0030, 16'h0BEE);

      @(posedge Clock); #1;
      chk("p_q_drained", 32'(p_q.size()), 32'd0);
      chk("l_q_drained", 32'(l_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
